true_dual_port_mem: RTL and testbench

TRUE_DUAL_PORT_MEM -- requirements
Module: true_dual_port_mem

---
 rtl/true_dual_port_mem.sv | 58 +++++
 tb/tb_true_dual_port_mem.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/true_dual_port_mem.sv
// True dual-port RAM: two independent read/write ports on one clock, 1-cycle registered reads.
// Optional macro TDPM_WRITE_FIRST_EN makes same-port writes write-first; the default is read-first.
module true_dual_port_mem #(
    parameter int  MEM_SIZE   = 1024,
    parameter int  DATA_WIDTH = 8,
    localparam int AW         = $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AW-1:0]         aa,
    input  logic [DATA_WIDTH-1:0] da,
    input  logic                  wa,
    output logic [DATA_WIDTH-1:0] qa,
    input  logic [AW-1:0]         ab,
    input  logic [DATA_WIDTH-1:0] db,
    input  logic                  wb,
    output logic [DATA_WIDTH-1:0] qb
);

    localparam logic [AW:0] LIMIT = (AW+1)'(MEM_SIZE);

    // Power-up contents are all zero; reset deliberately leaves them alone.
    logic [DATA_WIDTH-1:0] mem [MEM_SIZE] = '{default: '0};

    logic ok_a;
    logic ok_b;

    assign ok_a = ({1'b0, aa} < LIMIT);
    assign ok_b = ({1'b0, ab} < LIMIT);

    // Port B is written first so that port A wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wb && ok_b) mem[ab] <= db;
            if (wa && ok_a) mem[aa] <= da;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            qa <= '0;
            qb <= '0;
        end else begin
            if (!ok_a) qa <= '0;
`ifdef TDPM_WRITE_FIRST_EN
            else if (wa) qa <= da;
`endif
            else qa <= mem[aa];

            if (!ok_b) qb <= '0;
`ifdef TDPM_WRITE_FIRST_EN
            else if (wb) qb <= db;
`endif
            else qb <= mem[ab];
        end
    end

endmodule

// File: tb/tb_true_dual_port_mem.sv
// Bench for true_dual_port_mem: directed vector table, random traffic against a model,
// and an 11-bit / 1000-word instance for width and out-of-range behaviour.
module tb_true_dual_port_mem;

`ifdef TDPM_WRITE_FIRST_EN
    localparam bit WF = 1'b1;
`else
    localparam bit WF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, wa, wb;
    logic [9:0] aa, ab;
    logic [7:0] da, db, qa, qb;

    logic        reset2, wa2, wb2;
    logic [9:0]  aa2, ab2;
    logic [10:0] da2, db2, qa2, qb2;

    true_dual_port_mem u_dut (
        .clk(clk), .reset(reset),
        .aa(aa), .da(da), .wa(wa), .qa(qa),
        .ab(ab), .db(db), .wb(wb), .qb(qb)
    );

    true_dual_port_mem #(.MEM_SIZE(1000), .DATA_WIDTH(11)) u_w11 (
        .clk(clk), .reset(reset2),
        .aa(aa2), .da(da2), .wa(wa2), .qa(qa2),
        .ab(ab2), .db(db2), .wb(wb2), .qb(qb2)
    );

    typedef struct {
        logic       rst;
        logic       wa;
        logic [9:0] aa;
        logic [7:0] da;
        logic       wb;
        logic [9:0] ab;
        logic [7:0] db;
        logic       ca;
        logic [7:0] ea;
        logic       cb;
        logic [7:0] eb;
    } vec_t;

    typedef struct {
        logic       ca;
        logic [7:0] ea;
        logic       cb;
        logic [7:0] eb;
        logic [7:0] ma;
        logic [7:0] mb;
        string      name;
    } exp_t;

    exp_t sb[$];
    logic [10:0] sb2_a[$];
    logic [10:0] sb2_b[$];

    int checks   = 0;
    int failures = 0;

    logic [7:0] model [1024];
    vec_t       tbl [19];

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic wa_i, input logic [9:0] aa_i,
                                input logic [7:0] da_i, input logic wb_i, input logic [9:0] ab_i,
                                input logic [7:0] db_i, input logic ca, input logic [7:0] ea,
                                input logic cb, input logic [7:0] eb);
        vec_t v;
        v.rst = rst; v.wa = wa_i; v.aa = aa_i; v.da = da_i;
        v.wb = wb_i; v.ab = ab_i; v.db = db_i;
        v.ca = ca; v.ea = ea; v.cb = cb; v.eb = eb;
        return v;
    endfunction

    task automatic step(input vec_t v, input string name);
        exp_t e, got;
        @(negedge clk);
        reset = v.rst; wa = v.wa; aa = v.aa; da = v.da;
        wb = v.wb; ab = v.ab; db = v.db;
        e.ca = v.ca; e.ea = v.ea; e.cb = v.cb; e.eb = v.eb; e.name = name;
        if (v.rst) begin
            e.ma = 8'h00;
            e.mb = 8'h00;
        end else begin
            e.ma = (v.wa && WF) ? v.da : model[v.aa];
            e.mb = (v.wb && WF) ? v.db : model[v.ab];
            if (v.wb) model[v.ab] = v.db;
            if (v.wa) model[v.aa] = v.da;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        if (got.ca) check({got.name, "_qa"}, {3'b0, qa}, {3'b0, got.ea});
        if (got.cb) check({got.name, "_qb"}, {3'b0, qb}, {3'b0, got.eb});
        check({got.name, "_model_qa"}, {3'b0, qa}, {3'b0, got.ma});
        check({got.name, "_model_qb"}, {3'b0, qb}, {3'b0, got.mb});
    endtask

    task automatic step2(input logic rst, input logic w_a, input logic [9:0] a_a,
                         input logic [10:0] d_a, input logic w_b, input logic [9:0] a_b,
                         input logic [10:0] d_b, input logic [10:0] ea, input logic [10:0] eb,
                         input string name);
        @(negedge clk);
        reset2 = rst; wa2 = w_a; aa2 = a_a; da2 = d_a;
        wb2 = w_b; ab2 = a_b; db2 = d_b;
        sb2_a.push_back(ea);
        sb2_b.push_back(eb);
        @(posedge clk);
        #1;
        check({name, "_qa"}, qa2, sb2_a.pop_front());
        check({name, "_qb"}, qb2, sb2_b.pop_front());
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 1024; i++) model[i] = 8'h00;
        reset = 1'b1; wa = 1'b0; wb = 1'b0; aa = '0; ab = '0; da = '0; db = '0;
        reset2 = 1'b1; wa2 = 1'b0; wb2 = 1'b0; aa2 = '0; ab2 = '0; da2 = '0; db2 = '0;

        //            rst wa  aa     da     wb  ab     db     ca  ea     cb  eb
        tbl[0]  = mk(1, 0, 10'd0,    8'h00, 0, 10'd0,    8'h00, 1, 8'h00, 1, 8'h00);
        tbl[1]  = mk(0, 0, 10'd5,    8'h00, 0, 10'd5,    8'h00, 1, 8'h00, 1, 8'h00);
        tbl[2]  = mk(0, 1, 10'd5,    8'h3C, 0, 10'd0,    8'h00, 1, WF ? 8'h3C : 8'h00, 1, 8'h00);
        tbl[3]  = mk(0, 0, 10'd5,    8'h00, 0, 10'd5,    8'h00, 1, 8'h3C, 1, 8'h3C);
        tbl[4]  = mk(0, 1, 10'd7,    8'h11, 1, 10'd7,    8'h22, 1, WF ? 8'h11 : 8'h00, 1, WF ? 8'h22 : 8'h00);
        tbl[5]  = mk(0, 0, 10'd7,    8'h00, 0, 10'd7,    8'h00, 1, 8'h11, 1, 8'h11);
        tbl[6]  = mk(0, 1, 10'd9,    8'h05, 0, 10'd9,    8'h00, 0, 8'h00, 1, 8'h00);
        tbl[7]  = mk(0, 1, 10'd9,    8'h0A, 0, 10'd9,    8'h00, 1, WF ? 8'h0A : 8'h05, 1, 8'h05);
        tbl[8]  = mk(0, 0, 10'd9,    8'h00, 0, 10'd9,    8'h00, 1, 8'h0A, 1, 8'h0A);
        tbl[9]  = mk(0, 1, 10'd3,    8'h01, 0, 10'd0,    8'h00, 0, 8'h00, 0, 8'h00);
        tbl[10] = mk(0, 1, 10'd3,    8'h02, 0, 10'd0,    8'h00, 1, WF ? 8'h02 : 8'h01, 0, 8'h00);
        tbl[11] = mk(0, 0, 10'd3,    8'h00, 0, 10'd3,    8'h00, 1, 8'h02, 1, 8'h02);
        tbl[12] = mk(0, 1, 10'd1023, 8'hFF, 0, 10'd1023, 8'h00, 0, 8'h00, 1, 8'h00);
        tbl[13] = mk(1, 1, 10'd1023, 8'h00, 1, 10'd1023, 8'h00, 1, 8'h00, 1, 8'h00);
        tbl[14] = mk(1, 0, 10'd1023, 8'h00, 0, 10'd3,    8'h00, 1, 8'h00, 1, 8'h00);
        tbl[15] = mk(0, 0, 10'd1023, 8'h00, 0, 10'd1023, 8'h00, 1, 8'hFF, 1, 8'hFF);
        tbl[16] = mk(0, 0, 10'd20,   8'h00, 1, 10'd20,   8'h55, 1, 8'h00, 1, WF ? 8'h55 : 8'h00);
        tbl[17] = mk(0, 0, 10'd20,   8'h00, 0, 10'd20,   8'h00, 1, 8'h55, 1, 8'h55);
        tbl[18] = mk(0, 0, 10'd7,    8'h00, 0, 10'd5,    8'h00, 1, 8'h11, 1, 8'h3C);

        for (int i = 0; i < 19; i++) step(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 300; i++) begin
            v = mk(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                   10'($urandom_range(0, 15)), 8'($urandom),
                   1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 8'($urandom),
                   0, 8'h00, 0, 8'h00);
            step(v, $sformatf("rand%0d", i));
        end

        // 11-bit, 1000-word instance: width preservation and out-of-range addresses.
        step2(1, 0, 10'd0,    11'h000, 0, 10'd0,    11'h000, 11'h000, 11'h000, "w11_reset");
        step2(0, 1, 10'd0,    11'h7FF, 1, 10'd1,    11'h400, WF ? 11'h7FF : 11'h000,
              WF ? 11'h400 : 11'h000, "w11_write");
        step2(0, 0, 10'd1,    11'h000, 0, 10'd0,    11'h000, 11'h400, 11'h7FF, "w11_read");
        step2(0, 1, 10'd1000, 11'h123, 0, 10'd1000, 11'h000, 11'h000, 11'h000, "w11_oor_write");
        step2(0, 0, 10'd1000, 11'h000, 1, 10'd1023, 11'h2AA, 11'h000, 11'h000, "w11_oor_read");
        step2(0, 0, 10'd0,    11'h000, 0, 10'd1,    11'h000, 11'h7FF, 11'h400, "w11_intact");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
